// File: rtl/decode_issue_queue_pkg.sv
// Shared definitions for the decode issue queue: field widths, unit IDs, entry layout.
package decode_issue_queue_pkg;

    localparam int unsigned opcodeSize              = 12;
    localparam int unsigned addressWidth            = 64;
    localparam int unsigned funcUnitCodeSize        = 3;
    localparam int unsigned instructionCounterWidth = 64;
    localparam int unsigned instMinIdWidth          = 7;
    localparam int unsigned PidSize                 = 20;
    localparam int unsigned TidSize                 = 16;
    localparam int unsigned regAccessPatternSize    = 2;
    localparam int unsigned bodyWidth               = 84;

    // Operand access patterns
    localparam logic [regAccessPatternSize-1:0] regRead  = 2'b10;
    localparam logic [regAccessPatternSize-1:0] regWrite = 2'b01;

    // Functional unit identifiers
    typedef enum logic [funcUnitCodeSize-1:0] {
        fuFX     = 3'd0,
        fuFP     = 3'd1,
        fuVX     = 3'd2,
        fuCR     = 3'd3,
        fuLS     = 3'd4,
        fuBranch = 3'd6
    } funcUnit_t;

    // One decoded instruction as stored in the queue (MSB first)
    typedef struct packed {
        logic [opcodeSize-1:0]              opcode;
        logic [addressWidth-1:0]            address;
        funcUnit_t                          funcUnitType;
        logic [instructionCounterWidth-1:0] majID;
        logic [instMinIdWidth-1:0]          minID;
        logic                               is64Bit;
        logic [PidSize-1:0]                 pid;
        logic [TidSize-1:0]                 tid;
        logic [regAccessPatternSize-1:0]    op1rw;
        logic [regAccessPatternSize-1:0]    op2rw;
        logic [regAccessPatternSize-1:0]    op3rw;
        logic [regAccessPatternSize-1:0]    op4rw;
        logic                               op1IsReg;
        logic                               op2IsReg;
        logic                               op3IsReg;
        logic                               op4IsReg;
        logic [bodyWidth-1:0]               body;
    } queueEntry_t;

    localparam int unsigned entryWidth = $bits(queueEntry_t);

endpackage

// File: rtl/decode_issue_queue_ram.sv
// Queue storage: one synchronous write port, one asynchronous read port, not reset.
module decode_issue_queue_ram #(
    parameter int unsigned depth = 8,
    parameter int unsigned width = 283
) (
    input  logic                     clock_i,
    input  logic                     wrEn,
    input  logic [$clog2(depth)-1:0] wrAddr,
    input  logic [width-1:0]         wrData,
    input  logic [$clog2(depth)-1:0] rdAddr,
    output logic [width-1:0]         rdData
);

    logic [width-1:0] storage [depth];

    // Write port
    always_ff @(posedge clock_i) begin
        if (wrEn) begin
            storage[wrAddr] <= wrData;
        end
    end

    // Asynchronous read port for first-word-fall-through head
    assign rdData = storage[rdAddr];

endmodule

// File: rtl/decode_issue_queue.sv
// In-order instruction queue between DecodeMux and issue/rename, with early stall and flush.
import decode_issue_queue_pkg::*;

module decode_issue_queue #(
    parameter int unsigned depth          = 8,
    parameter int unsigned stallThreshold = 6
) (
    input  logic                               clock_i,
    input  logic                               reset_i,
    input  logic                               flush_i,
    input  logic                               enable_i,
    input  logic [opcodeSize-1:0]              opcode_i,
    input  logic [addressWidth-1:0]            address_i,
    input  logic [funcUnitCodeSize-1:0]        funcUnitType_i,
    input  logic [instructionCounterWidth-1:0] majID_i,
    input  logic [instMinIdWidth-1:0]          minID_i,
    input  logic                               is64Bit_i,
    input  logic [PidSize-1:0]                 pid_i,
    input  logic [TidSize-1:0]                 tid_i,
    input  logic [regAccessPatternSize-1:0]    op1rw_i,
    input  logic [regAccessPatternSize-1:0]    op2rw_i,
    input  logic [regAccessPatternSize-1:0]    op3rw_i,
    input  logic [regAccessPatternSize-1:0]    op4rw_i,
    input  logic                               op1IsReg_i,
    input  logic                               op2IsReg_i,
    input  logic                               op3IsReg_i,
    input  logic                               op4IsReg_i,
    input  logic [bodyWidth-1:0]               body_i,
    output logic                               stall_o,
    output logic                               overflow_o,
    output logic                               valid_o,
    input  logic                               ready_i,
    output logic [opcodeSize-1:0]              opcode_o,
    output logic [addressWidth-1:0]            address_o,
    output logic [funcUnitCodeSize-1:0]        funcUnitType_o,
    output logic [instructionCounterWidth-1:0] majID_o,
    output logic [instMinIdWidth-1:0]          minID_o,
    output logic                               is64Bit_o,
    output logic [PidSize-1:0]                 pid_o,
    output logic [TidSize-1:0]                 tid_o,
    output logic [regAccessPatternSize-1:0]    op1rw_o,
    output logic [regAccessPatternSize-1:0]    op2rw_o,
    output logic [regAccessPatternSize-1:0]    op3rw_o,
    output logic [regAccessPatternSize-1:0]    op4rw_o,
    output logic                               op1IsReg_o,
    output logic                               op2IsReg_o,
    output logic                               op3IsReg_o,
    output logic                               op4IsReg_o,
    output logic [bodyWidth-1:0]               body_o,
    output logic [$clog2(depth):0]             count_o
);

    localparam int unsigned addrWidth = $clog2(depth);
    localparam int unsigned ptrWidth  = addrWidth + 1;

    logic [ptrWidth-1:0] wrPtr;
    logic [ptrWidth-1:0] rdPtr;
    logic [ptrWidth-1:0] wrPtrNext;
    logic [ptrWidth-1:0] rdPtrNext;
    logic [ptrWidth-1:0] countNext;
    logic                stallNext;
    logic                overflowNext;
    logic                full;
    logic                empty;
    logic                push;
    logic                pop;
    logic                wrEn;

    queueEntry_t             wrEntry;
    queueEntry_t             rdEntry;
    queueEntry_t             headEntry;
    logic [entryWidth-1:0]   rdData;

    // Occupancy flags from the extra pointer wrap bit
    assign empty = (wrPtr == rdPtr);
    assign full  = (wrPtr[addrWidth] != rdPtr[addrWidth]) &&
                   (wrPtr[addrWidth-1:0] == rdPtr[addrWidth-1:0]);

    assign valid_o = !empty;
    assign count_o = wrPtr - rdPtr;

    // Handshake; a pop frees the slot so a push into a full queue still lands
    assign pop  = valid_o && ready_i;
    assign push = enable_i && (!full || pop);
    assign wrEn = push && !flush_i;

    // Pointer, stall and overflow next-state; flush overrides any push/pop
    always_comb begin
        wrPtrNext    = wrPtr;
        rdPtrNext    = rdPtr;
        overflowNext = overflow_o;
        if (flush_i) begin
            wrPtrNext = '0;
            rdPtrNext = '0;
        end else begin
            if (push) begin
                wrPtrNext = wrPtr + ptrWidth'(1);
            end
            if (pop) begin
                rdPtrNext = rdPtr + ptrWidth'(1);
            end
            if (enable_i && full && !pop) begin
                overflowNext = 1'b1;
            end
        end
        countNext = wrPtrNext - rdPtrNext;
        stallNext = (countNext >= ptrWidth'(stallThreshold));
    end

    // Control state registers
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            wrPtr      <= '0;
            rdPtr      <= '0;
            stall_o    <= 1'b0;
            overflow_o <= 1'b0;
        end else begin
            wrPtr      <= wrPtrNext;
            rdPtr      <= rdPtrNext;
            stall_o    <= stallNext;
            overflow_o <= overflowNext;
        end
    end

    // Pack incoming instruction fields
    always_comb begin
        wrEntry              = '0;
        wrEntry.opcode       = opcode_i;
        wrEntry.address      = address_i;
        wrEntry.funcUnitType = funcUnit_t'(funcUnitType_i);
        wrEntry.majID        = majID_i;
        wrEntry.minID        = minID_i;
        wrEntry.is64Bit      = is64Bit_i;
        wrEntry.pid          = pid_i;
        wrEntry.tid          = tid_i;
        wrEntry.op1rw        = op1rw_i;
        wrEntry.op2rw        = op2rw_i;
        wrEntry.op3rw        = op3rw_i;
        wrEntry.op4rw        = op4rw_i;
        wrEntry.op1IsReg     = op1IsReg_i;
        wrEntry.op2IsReg     = op2IsReg_i;
        wrEntry.op3IsReg     = op3IsReg_i;
        wrEntry.op4IsReg     = op4IsReg_i;
        wrEntry.body         = body_i;
    end

    decode_issue_queue_ram #(
        .depth (depth),
        .width (entryWidth)
    ) u_ram (
        .clock_i (clock_i),
        .wrEn    (wrEn),
        .wrAddr  (wrPtr[addrWidth-1:0]),
        .wrData  (wrEntry),
        .rdAddr  (rdPtr[addrWidth-1:0]),
        .rdData  (rdData)
    );

    assign rdEntry = queueEntry_t'(rdData);

    // Head payload is zero whenever nothing valid is presented
    always_comb begin
        headEntry = '0;
        if (valid_o) begin
            headEntry = rdEntry;
        end
    end

    // Unpack head entry onto output fields
    assign opcode_o       = headEntry.opcode;
    assign address_o      = headEntry.address;
    assign funcUnitType_o = funcUnitCodeSize'(headEntry.funcUnitType);
    assign majID_o        = headEntry.majID;
    assign minID_o        = headEntry.minID;
    assign is64Bit_o      = headEntry.is64Bit;
    assign pid_o          = headEntry.pid;
    assign tid_o          = headEntry.tid;
    assign op1rw_o        = headEntry.op1rw;
    assign op2rw_o        = headEntry.op2rw;
    assign op3rw_o        = headEntry.op3rw;
    assign op4rw_o        = headEntry.op4rw;
    assign op1IsReg_o     = headEntry.op1IsReg;
    assign op2IsReg_o     = headEntry.op2IsReg;
    assign op3IsReg_o     = headEntry.op3IsReg;
    assign op4IsReg_o     = headEntry.op4IsReg;
    assign body_o         = headEntry.body;

endmodule

// File: tb/tb_decode_issue_queue.sv
// Directed bench for decode_issue_queue: handshake, stall, overflow, wrap, flush, async reset.
module tb_decode_issue_queue;

    logic        clock_i = 1'b0;
    logic        reset_i;
    logic        flush_i;
    logic        enable_i;
    logic [11:0] opcode_i;
    logic [63:0] address_i;
    logic [2:0]  funcUnitType_i;
    logic [63:0] majID_i;
    logic [6:0]  minID_i;
    logic        is64Bit_i;
    logic [19:0] pid_i;
    logic [15:0] tid_i;
    logic [1:0]  op1rw_i, op2rw_i, op3rw_i, op4rw_i;
    logic        op1IsReg_i, op2IsReg_i, op3IsReg_i, op4IsReg_i;
    logic [83:0] body_i;
    logic        stall_o, overflow_o, valid_o, ready_i;
    logic [11:0] opcode_o;
    logic [63:0] address_o;
    logic [2:0]  funcUnitType_o;
    logic [63:0] majID_o;
    logic [6:0]  minID_o;
    logic        is64Bit_o;
    logic [19:0] pid_o;
    logic [15:0] tid_o;
    logic [1:0]  op1rw_o, op2rw_o, op3rw_o, op4rw_o;
    logic        op1IsReg_o, op2IsReg_o, op3IsReg_o, op4IsReg_o;
    logic [83:0] body_o;
    logic [3:0]  count_o;

    int nCompared   = 0;
    int nMismatched = 0;

    always #5 clock_i = ~clock_i;

    decode_issue_queue #(.depth(8), .stallThreshold(6)) dut (
        .clock_i(clock_i), .reset_i(reset_i), .flush_i(flush_i), .enable_i(enable_i),
        .opcode_i(opcode_i), .address_i(address_i), .funcUnitType_i(funcUnitType_i),
        .majID_i(majID_i), .minID_i(minID_i), .is64Bit_i(is64Bit_i), .pid_i(pid_i),
        .tid_i(tid_i), .op1rw_i(op1rw_i), .op2rw_i(op2rw_i), .op3rw_i(op3rw_i),
        .op4rw_i(op4rw_i), .op1IsReg_i(op1IsReg_i), .op2IsReg_i(op2IsReg_i),
        .op3IsReg_i(op3IsReg_i), .op4IsReg_i(op4IsReg_i), .body_i(body_i),
        .stall_o(stall_o), .overflow_o(overflow_o), .valid_o(valid_o), .ready_i(ready_i),
        .opcode_o(opcode_o), .address_o(address_o), .funcUnitType_o(funcUnitType_o),
        .majID_o(majID_o), .minID_o(minID_o), .is64Bit_o(is64Bit_o), .pid_o(pid_o),
        .tid_o(tid_o), .op1rw_o(op1rw_o), .op2rw_o(op2rw_o), .op3rw_o(op3rw_o),
        .op4rw_o(op4rw_o), .op1IsReg_o(op1IsReg_o), .op2IsReg_o(op2IsReg_o),
        .op3IsReg_o(op3IsReg_o), .op4IsReg_o(op4IsReg_o), .body_o(body_o),
        .count_o(count_o)
    );

    // Advance one clock and settle past the edge
    task automatic step();
        @(posedge clock_i);
        #1;
    endtask

    // Expected payload model keyed by majID
    function automatic logic [11:0] expOpcode(input logic [63:0] id);
        return 12'(id + 64'd256);
    endfunction
    function automatic logic [63:0] expAddress(input logic [63:0] id);
        return (id << 3) + 64'h0000_0000_0000_4000;
    endfunction
    function automatic logic [83:0] expBody(input logic [63:0] id);
        return {id, id[19:0]};
    endfunction

    // Drive an instruction whose fields are derived from its majID
    task automatic driveInst(input logic [63:0] id);
        opcode_i       = expOpcode(id);
        address_i      = expAddress(id);
        funcUnitType_i = 3'(id % 64'd5);
        majID_i        = id;
        minID_i        = 7'(id);
        is64Bit_i      = id[0];
        pid_i          = 20'(id) ^ 20'hABCDE;
        tid_i          = 16'(id) + 16'h0100;
        op1rw_i = 2'b01; op2rw_i = 2'b10; op3rw_i = 2'b10; op4rw_i = 2'b00;
        op1IsReg_i = 1'b1; op2IsReg_i = 1'b1; op3IsReg_i = id[1]; op4IsReg_i = 1'b0;
        body_i         = expBody(id);
    endtask

    task automatic test_reset();
        reset_i = 1'b0; flush_i = 1'b0; enable_i = 1'b0; ready_i = 1'b0;
        driveInst(64'd0);
        #12;
        nCompared++;
        if (count_o !== 4'd0 || valid_o !== 1'b0 || stall_o !== 1'b0 || overflow_o !== 1'b0) begin
            nMismatched++;
            $display("FAIL reset_flags: count=%0d valid=%b stall=%b ovf=%b, need 0/0/0/0",
                     count_o, valid_o, stall_o, overflow_o);
        end
        nCompared++;
        if (opcode_o !== 12'd0 || majID_o !== 64'd0 || body_o !== 84'd0) begin
            nMismatched++;
            $display("FAIL reset_payload: opcode=%h majID=%h body=%h, need zero", opcode_o, majID_o, body_o);
        end
        @(negedge clock_i);
        reset_i = 1'b1;
        step();
    endtask

    task automatic test_single_fp();
        logic [83:0] fpBody;
        fpBody = 84'(21'b10001_01110_11111_00000_1);
        opcode_i = 12'd4; address_i = 64'h0000_0000_0040_0010; funcUnitType_i = 3'd1;
        majID_i = 64'hA5; minID_i = 7'd5; is64Bit_i = 1'b1; pid_i = 20'h12345; tid_i = 16'hBEEF;
        op1rw_i = 2'b01; op2rw_i = 2'b10; op3rw_i = 2'b10; op4rw_i = 2'b00;
        op1IsReg_i = 1'b1; op2IsReg_i = 1'b1; op3IsReg_i = 1'b1; op4IsReg_i = 1'b0;
        body_i = fpBody;
        enable_i = 1'b1; ready_i = 1'b1;
        step();
        enable_i = 1'b0;
        nCompared++;
        if (valid_o !== 1'b1 || count_o !== 4'd1) begin
            nMismatched++;
            $display("FAIL fp_valid: valid=%b count=%0d, need 1/1", valid_o, count_o);
        end
        nCompared++;
        if (opcode_o !== 12'd4 || funcUnitType_o !== 3'd1 || body_o !== fpBody ||
            address_o !== 64'h0000_0000_0040_0010) begin
            nMismatched++;
            $display("FAIL fp_fields: opcode=%h fu=%h body=%h addr=%h", opcode_o, funcUnitType_o, body_o, address_o);
        end
        nCompared++;
        if (majID_o !== 64'hA5 || minID_o !== 7'd5 || is64Bit_o !== 1'b1 || pid_o !== 20'h12345 ||
            tid_o !== 16'hBEEF) begin
            nMismatched++;
            $display("FAIL fp_ids: maj=%h min=%h is64=%b pid=%h tid=%h", majID_o, minID_o, is64Bit_o, pid_o, tid_o);
        end
        nCompared++;
        if ({op1rw_o, op2rw_o, op3rw_o, op4rw_o} !== 8'b01_10_10_00 ||
            {op1IsReg_o, op2IsReg_o, op3IsReg_o, op4IsReg_o} !== 4'b1110) begin
            nMismatched++;
            $display("FAIL fp_operands: rw=%b%b%b%b isReg=%b%b%b%b, need 01101000/1110",
                     op1rw_o, op2rw_o, op3rw_o, op4rw_o, op1IsReg_o, op2IsReg_o, op3IsReg_o, op4IsReg_o);
        end
        step();
        ready_i = 1'b0;
        nCompared++;
        if (count_o !== 4'd0 || valid_o !== 1'b0) begin
            nMismatched++;
            $display("FAIL fp_drained: count=%0d valid=%b, need 0/0", count_o, valid_o);
        end
    endtask

    task automatic test_fill_stall();
        ready_i = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            driveInst(64'(i));
            enable_i = 1'b1;
            step();
            if (i == 5) begin
                nCompared++;
                if (stall_o !== 1'b0 || count_o !== 4'd5) begin
                    nMismatched++;
                    $display("FAIL stall_at5: stall=%b count=%0d, need 0/5", stall_o, count_o);
                end
            end
            if (i == 6) begin
                nCompared++;
                if (stall_o !== 1'b1 || count_o !== 4'd6) begin
                    nMismatched++;
                    $display("FAIL stall_at6: stall=%b count=%0d, need 1/6", stall_o, count_o);
                end
            end
        end
        enable_i = 1'b0;
        nCompared++;
        if (count_o !== 4'd8 || overflow_o !== 1'b0 || stall_o !== 1'b1 || majID_o !== 64'd1) begin
            nMismatched++;
            $display("FAIL full8: count=%0d ovf=%b stall=%b head=%0d, need 8/0/1/1",
                     count_o, overflow_o, stall_o, majID_o);
        end
    endtask

    task automatic test_overflow();
        driveInst(64'd99);
        enable_i = 1'b1; ready_i = 1'b0;
        step();
        enable_i = 1'b0;
        nCompared++;
        if (overflow_o !== 1'b1 || count_o !== 4'd8 || majID_o !== 64'd1) begin
            nMismatched++;
            $display("FAIL overflow_drop: ovf=%b count=%0d head=%0d, need 1/8/1", overflow_o, count_o, majID_o);
        end
        step();
        nCompared++;
        if (overflow_o !== 1'b1) begin
            nMismatched++;
            $display("FAIL overflow_sticky: ovf=%b, need 1", overflow_o);
        end
    endtask

    task automatic test_back_to_back();
        driveInst(64'd9);
        enable_i = 1'b1; ready_i = 1'b1;
        step();
        enable_i = 1'b0;
        nCompared++;
        if (count_o !== 4'd8 || majID_o !== 64'd2) begin
            nMismatched++;
            $display("FAIL full_push_pop: count=%0d head=%0d, need 8/2", count_o, majID_o);
        end
        for (int k = 2; k <= 9; k++) begin
            nCompared++;
            if (valid_o !== 1'b1 || majID_o !== 64'(k) || minID_o !== 7'(k) ||
                opcode_o !== expOpcode(64'(k)) || address_o !== expAddress(64'(k)) ||
                body_o !== expBody(64'(k))) begin
                nMismatched++;
                $display("FAIL drain_%0d: valid=%b maj=%0d min=%0d opcode=%h, need 1/%0d", k,
                         valid_o, majID_o, minID_o, opcode_o, k);
            end
            step();
        end
        ready_i = 1'b0;
        nCompared++;
        if (count_o !== 4'd0 || valid_o !== 1'b0 || stall_o !== 1'b0) begin
            nMismatched++;
            $display("FAIL drain_empty: count=%0d valid=%b stall=%b, need 0/0/0", count_o, valid_o, stall_o);
        end
    endtask

    task automatic test_flush();
        ready_i = 1'b0;
        for (int i = 20; i <= 24; i++) begin
            driveInst(64'(i));
            enable_i = 1'b1;
            step();
        end
        nCompared++;
        if (count_o !== 4'd5 || majID_o !== 64'd20) begin
            nMismatched++;
            $display("FAIL preflush: count=%0d head=%0d, need 5/20", count_o, majID_o);
        end
        driveInst(64'd25);
        flush_i = 1'b1; enable_i = 1'b1; ready_i = 1'b1;
        step();
        flush_i = 1'b0; enable_i = 1'b0; ready_i = 1'b0;
        nCompared++;
        if (count_o !== 4'd0 || valid_o !== 1'b0 || stall_o !== 1'b0 || opcode_o !== 12'd0) begin
            nMismatched++;
            $display("FAIL flush: count=%0d valid=%b stall=%b opcode=%h, need 0/0/0/0",
                     count_o, valid_o, stall_o, opcode_o);
        end
        nCompared++;
        if (overflow_o !== 1'b1) begin
            nMismatched++;
            $display("FAIL flush_ovf_kept: ovf=%b, need 1", overflow_o);
        end
        driveInst(64'd30);
        enable_i = 1'b1;
        step();
        enable_i = 1'b0;
        nCompared++;
        if (count_o !== 4'd1 || majID_o !== 64'd30) begin
            nMismatched++;
            $display("FAIL postflush_push: count=%0d head=%0d, need 1/30", count_o, majID_o);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 31; i <= 35; i++) begin
            driveInst(64'(i));
            enable_i = 1'b1;
            step();
        end
        enable_i = 1'b0;
        nCompared++;
        if (count_o !== 4'd6 || stall_o !== 1'b1) begin
            nMismatched++;
            $display("FAIL prereset: count=%0d stall=%b, need 6/1", count_o, stall_o);
        end
        #2;
        reset_i = 1'b0;
        #1;
        nCompared++;
        if (count_o !== 4'd0 || valid_o !== 1'b0 || stall_o !== 1'b0 || overflow_o !== 1'b0 ||
            majID_o !== 64'd0) begin
            nMismatched++;
            $display("FAIL async_reset: count=%0d valid=%b stall=%b ovf=%b maj=%0d, need all 0",
                     count_o, valid_o, stall_o, overflow_o, majID_o);
        end
        @(negedge clock_i);
        reset_i = 1'b1;
        driveInst(64'd40);
        step();
        nCompared++;
        if (count_o !== 4'd0 || valid_o !== 1'b0) begin
            nMismatched++;
            $display("FAIL reset_release: count=%0d valid=%b, need 0/0", count_o, valid_o);
        end
        enable_i = 1'b1;
        step();
        enable_i = 1'b0;
        nCompared++;
        if (count_o !== 4'd1 || majID_o !== 64'd40 || valid_o !== 1'b1) begin
            nMismatched++;
            $display("FAIL post_reset_push: count=%0d head=%0d valid=%b, need 1/40/1",
                     count_o, majID_o, valid_o);
        end
    endtask

    initial begin
        test_reset();
        test_single_fp();
        test_fill_stall();
        test_overflow();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
